// File: rtl/axi_tile_unpacker.sv
// axi_tile_unpacker
//   Accepts a burst of wide AXI read-data beats and scatters each beat into a
//   ROWS x COLS array of BANK_W-bit banks. A single cfg_start pulse configures
//   and launches a transfer; beat sequencing, bank addressing and end-of-burst
//   checking are internal.
//
//   Modes:
//     PACK   (cfg_ext=0) : bank word k = s_data[k*BANK_W +: BANK_W]
//     EXTEND (cfg_ext=1) : bank word k = element k of width 4/8/16/32 bits,
//                          zero- or sign-extended to BANK_W (assumes BANK_W >= 32)
//
//   Ports:
//     clk, rst_n          clock, synchronous active-low reset
//     cfg_start           one-cycle pulse, latches cfg_* and (re)starts a transfer
//     cfg_beats           beats expected (0 = complete immediately)
//     cfg_words           bank words per beat (0 or > WPB means WPB)
//     cfg_ext/ew/sext     packing mode, element width code, sign-extend select
//     cfg_base            first linear bank index
//     s_valid/s_ready/s_data/s_last   AXI R channel
//     wr_en/wr_data       per-bank write strobe and data, bank (r,c) at r*COLS+c
//     busy, done, err_last   status: in progress, completion pulse, sticky last error
module axi_tile_unpacker #(
    parameter int unsigned DATA_W = 256,
    parameter int unsigned BANK_W = 32,
    parameter int unsigned ROWS   = 8,
    parameter int unsigned COLS   = 8,
    parameter int unsigned BEAT_W = 8
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              cfg_start,
    input  logic [BEAT_W-1:0]                 cfg_beats,
    input  logic [$clog2(DATA_W/BANK_W):0]    cfg_words,
    input  logic                              cfg_ext,
    input  logic [1:0]                        cfg_ew,
    input  logic                              cfg_sext,
    input  logic [$clog2(ROWS*COLS)-1:0]      cfg_base,
    input  logic                              s_valid,
    output logic                              s_ready,
    input  logic [DATA_W-1:0]                 s_data,
    input  logic                              s_last,
    output logic [ROWS*COLS-1:0]              wr_en,
    output logic [ROWS*COLS*BANK_W-1:0]       wr_data,
    output logic                              busy,
    output logic                              done,
    output logic                              err_last
);

    localparam int unsigned WPB     = DATA_W / BANK_W;
    localparam int unsigned NB      = ROWS * COLS;
    localparam int unsigned IDX_W   = $clog2(NB);
    localparam int unsigned WORDS_W = $clog2(WPB) + 1;
    localparam logic [BEAT_W:0] CNT_ONE = 1;

    typedef enum logic {StIdle, StRun} state_e;

    state_e                    state_q, state_d;
    logic [IDX_W-1:0]          ptr_q, ptr_d;
    logic [BEAT_W-1:0]         beat_cnt_q, beat_cnt_d;
    logic [BEAT_W-1:0]         beats_q, beats_d;
    logic [WORDS_W-1:0]        words_q, words_d;
    logic                      ext_q, ext_d;
    logic [1:0]                ew_q, ew_d;
    logic                      sext_q, sext_d;
    logic                      err_q, err_d;
    logic                      done_q, done_d;
    logic [NB-1:0]             wr_en_q, wr_en_d;
    logic [NB*BANK_W-1:0]      wr_data_q, wr_data_d;

    logic                      accept;
    logic                      final_beat;
    logic [BEAT_W:0]           cnt_inc;
    logic [WORDS_W-1:0]        words_eff;
    int unsigned               idx;

    // Extract bank word k of the current beat according to the latched mode.
    function automatic logic [BANK_W-1:0] beat_word(
        input logic [DATA_W-1:0] data,
        input int unsigned       k,
        input logic              ext,
        input logic [1:0]        ew,
        input logic              sext
    );
        logic [DATA_W-1:0] sh;
        logic [BANK_W-1:0] w;
        if (!ext) begin
            sh = data >> (k * BANK_W);
            w  = sh[BANK_W-1:0];
        end else begin
            case (ew)
                2'd0: begin
                    sh = data >> (k * 4);
                    w  = {{(BANK_W-4){sext & sh[3]}}, sh[3:0]};
                end
                2'd1: begin
                    sh = data >> (k * 8);
                    w  = {{(BANK_W-8){sext & sh[7]}}, sh[7:0]};
                end
                2'd2: begin
                    sh = data >> (k * 16);
                    w  = {{(BANK_W-16){sext & sh[15]}}, sh[15:0]};
                end
                default: begin
                    sh = data >> (k * 32);
                    w  = BANK_W'(sh[31:0]);
                end
            endcase
        end
        return w;
    endfunction

    assign s_ready    = (state_q == StRun);
    assign accept     = s_valid && s_ready;
    assign cnt_inc    = {1'b0, beat_cnt_q} + CNT_ONE;
    assign final_beat = (cnt_inc == {1'b0, beats_q});
    assign words_eff  = (words_q == '0 || words_q > WORDS_W'(WPB)) ? WORDS_W'(WPB) : words_q;

    assign busy     = s_ready || done_q;
    assign done     = done_q;
    assign err_last = err_q;
    assign wr_en    = wr_en_q;
    assign wr_data  = wr_data_q;

    // State register and all registered datapath/outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            ptr_q      <= '0;
            beat_cnt_q <= '0;
            beats_q    <= '0;
            words_q    <= '0;
            ext_q      <= 1'b0;
            ew_q       <= '0;
            sext_q     <= 1'b0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
            wr_en_q    <= '0;
            wr_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            beat_cnt_q <= beat_cnt_d;
            beats_q    <= beats_d;
            words_q    <= words_d;
            ext_q      <= ext_d;
            ew_q       <= ew_d;
            sext_q     <= sext_d;
            err_q      <= err_d;
            done_q     <= done_d;
            wr_en_q    <= wr_en_d;
            wr_data_q  <= wr_data_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (cfg_start && cfg_beats != '0) state_d = StRun;
            end
            StRun: begin
                // A new command always wins over an in-flight beat.
                if (cfg_start) begin
                    state_d = (cfg_beats != '0) ? StRun : StIdle;
                end else if (accept && (final_beat || s_last)) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Datapath and registered-output next values.
    always_comb begin
        ptr_d      = ptr_q;
        beat_cnt_d = beat_cnt_q;
        beats_d    = beats_q;
        words_d    = words_q;
        ext_d      = ext_q;
        ew_d       = ew_q;
        sext_d     = sext_q;
        err_d      = err_q;
        done_d     = 1'b0;
        wr_en_d    = '0;
        wr_data_d  = '0;
        idx        = 0;
        if (cfg_start) begin
            beats_d    = cfg_beats;
            words_d    = cfg_words;
            ext_d      = cfg_ext;
            ew_d       = cfg_ew;
            sext_d     = cfg_sext;
            ptr_d      = cfg_base;
            beat_cnt_d = '0;
            err_d      = 1'b0;
            done_d     = (cfg_beats == '0);
        end else if (accept) begin
            for (int unsigned k = 0; k < WPB; k++) begin
                if (k < 32'(words_eff)) begin
                    idx = (32'(ptr_q) + k) % NB;
                    wr_en_d[idx] = 1'b1;
                    wr_data_d[idx*BANK_W +: BANK_W] = beat_word(s_data, k, ext_q, ew_q, sext_q);
                end
            end
            ptr_d      = IDX_W'((32'(ptr_q) + 32'(words_eff)) % NB);
            beat_cnt_d = cnt_inc[BEAT_W-1:0];
            if (final_beat || s_last) done_d = 1'b1;
            // Flag both a missing last on the final beat and an early last.
            if (final_beat != s_last) err_d = 1'b1;
        end
    end

endmodule

// File: tb/tb_axi_tile_unpacker.sv
module tb_axi_tile_unpacker;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            cfg_start = 1'b0;
    logic [7:0]      cfg_beats = '0;
    logic [3:0]      cfg_words = '0;
    logic            cfg_ext = 1'b0;
    logic [1:0]      cfg_ew = '0;
    logic            cfg_sext = 1'b0;
    logic [5:0]      cfg_base = '0;
    logic            s_valid = 1'b0;
    logic            s_ready;
    logic [255:0]    s_data = '0;
    logic            s_last = 1'b0;
    logic [63:0]     wr_en;
    logic [2047:0]   wr_data;
    logic            busy;
    logic            done;
    logic            err_last;

    axi_tile_unpacker dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_start (cfg_start),
        .cfg_beats (cfg_beats),
        .cfg_words (cfg_words),
        .cfg_ext   (cfg_ext),
        .cfg_ew    (cfg_ew),
        .cfg_sext  (cfg_sext),
        .cfg_base  (cfg_base),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_last    (s_last),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .busy      (busy),
        .done      (done),
        .err_last  (err_last)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    // Reference model: transfer state as the spec describes it.
    bit  m_run = 0;
    int  m_ptr = 0, m_cnt = 0, m_beats = 0, m_words = 0, m_ew = 0;
    bit  m_ext = 0, m_sext = 0, m_err = 0;
    logic [63:0]   e_en = '0;
    logic [2047:0] e_data = '0;
    bit            e_done = 0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] expv);
        n_chk++;
        if (act !== expv) $display("FAIL %s: got %h expected %h", name, act, expv);
        else n_pass++;
    endfunction

    function automatic void chk_wr(string name);
        n_chk++;
        if (wr_en !== e_en || wr_data !== e_data) begin
            for (int b = 0; b < 64; b++) begin
                if (wr_en[b] !== e_en[b] || wr_data[b*32 +: 32] !== e_data[b*32 +: 32]) begin
                    $display("FAIL %s: bank %0d en=%b data=%h expected en=%b data=%h", name, b,
                             wr_en[b], wr_data[b*32 +: 32], e_en[b], e_data[b*32 +: 32]);
                    break;
                end
            end
        end else n_pass++;
    endfunction

    function automatic logic [255:0] rnd256();
        return {$urandom, $urandom, $urandom, $urandom,
                $urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [31:0] exp_word(logic [255:0] d, int k, bit ext, int ew, bit sext);
        int b;
        logic [63:0] mask, e;
        if (!ext) return d[k*32 +: 32];
        b = 4 << ew;
        mask = (64'd1 << b) - 64'd1;
        e = 64'(d >> (k * b)) & mask;
        if (sext && ((e >> (b - 1)) & 64'd1) == 64'd1) e = e | ~mask;
        return e[31:0];
    endfunction

    // One clock: predict from the inputs now applied, then check just after the edge.
    task automatic tick();
        logic [63:0]   en_n;
        logic [2047:0] dat_n;
        bit            done_n, fin;
        int            w, idx;
        en_n = '0; dat_n = '0; done_n = 0;
        if (!rst_n) begin
            m_run = 0; m_ptr = 0; m_cnt = 0; m_err = 0;
        end else if (cfg_start) begin
            m_beats = cfg_beats; m_words = cfg_words; m_ext = cfg_ext;
            m_ew = cfg_ew; m_sext = cfg_sext;
            m_ptr = cfg_base; m_cnt = 0; m_err = 0;
            m_run = (cfg_beats != 0); done_n = (cfg_beats == 0);
        end else if (m_run && s_valid) begin
            w = (m_words == 0 || m_words > 8) ? 8 : m_words;
            for (int k = 0; k < w; k++) begin
                idx = (m_ptr + k) % 64;
                en_n[idx] = 1'b1;
                dat_n[idx*32 +: 32] = exp_word(s_data, k, m_ext, m_ew, m_sext);
            end
            m_ptr = (m_ptr + w) % 64;
            m_cnt++;
            fin = (m_cnt == m_beats);
            if (fin || s_last) begin
                done_n = 1; m_run = 0;
                if (fin != s_last) m_err = 1;
            end
        end
        @(posedge clk);
        e_en = en_n; e_data = dat_n; e_done = done_n;
        #1;
        chk_wr("wr");
        chk("s_ready", 64'(s_ready), 64'(m_run));
        chk("done", 64'(done), 64'(e_done));
        chk("busy", 64'(busy), 64'(m_run || e_done));
        chk("err_last", 64'(err_last), 64'(m_err));
    endtask

    task automatic start(bit ext, int ew, bit sext, int words, int base, int beats, bit v);
        cfg_ext = ext; cfg_ew = 2'(ew); cfg_sext = sext; cfg_words = 4'(words);
        cfg_base = 6'(base); cfg_beats = 8'(beats);
        cfg_start = 1'b1; s_valid = v; s_data = rnd256(); s_last = 1'b0;
        tick();
        cfg_start = 1'b0; s_valid = 1'b0;
    endtask

    // Offer up to n beats with random gaps; stops when the model says the burst ended.
    task automatic drive(int n, int gap, int last_at);
        int sent = 0;
        for (int g = 0; g < 200 && sent < n && m_run; g++) begin
            s_valid = ($urandom_range(0, 99) >= gap);
            s_data  = rnd256();
            s_last  = (sent == last_at);
            if (s_valid) sent++;
            tick();
        end
        s_valid = 1'b0; s_last = 1'b0;
    endtask

    typedef struct {
        bit          ext;
        int          ew;
        bit          sext;
        logic [31:0] elem;
        logic [31:0] expv;
    } ext_vec_t;

    ext_vec_t     ev[9];
    logic [255:0] vdata;
    logic [63:0]  mask;
    logic [63:0]  wrap_exp[3];
    bit           pat[7];
    int           sent, nb, mode, b;

    initial begin
        ev[0] = '{0, 0, 0, 32'hDEADBEEF, 32'hDEADBEEF};
        ev[1] = '{1, 0, 1, 32'h8,        32'hFFFFFFF8};
        ev[2] = '{1, 0, 0, 32'h8,        32'h00000008};
        ev[3] = '{1, 1, 1, 32'h80,       32'hFFFFFF80};
        ev[4] = '{1, 1, 1, 32'h7F,       32'h0000007F};
        ev[5] = '{1, 1, 0, 32'h80,       32'h00000080};
        ev[6] = '{1, 2, 1, 32'h8000,     32'hFFFF8000};
        ev[7] = '{1, 2, 0, 32'h8001,     32'h00008001};
        ev[8] = '{1, 3, 1, 32'h80000001, 32'h80000001};
        wrap_exp[0] = 64'hC000_0000_0000_0000;
        wrap_exp[1] = 64'h3;
        wrap_exp[2] = 64'hC;
        pat = '{1, 0, 0, 1, 1, 0, 1};

        // Reset state
        rst_n = 1'b0;
        tick();
        tick();
        chk("reset_wr_en", wr_en, 64'h0);
        chk("reset_ready", 64'(s_ready), 64'h0);
        rst_n = 1'b1;
        tick();

        // Extension / pack table: one beat, 8 words into row 2
        for (int i = 0; i < 9; i++) begin
            b = ev[i].ext ? (4 << ev[i].ew) : 32;
            mask = (64'd1 << b) - 64'd1;
            vdata = '0;
            for (int k = 0; k < 256 / b; k++)
                vdata = vdata | (256'(64'(ev[i].elem) & mask) << (k * b));
            start(ev[i].ext, ev[i].ew, ev[i].sext, 8, 16, 1, 0);
            s_valid = 1'b1; s_data = vdata; s_last = 1'b1;
            tick();
            s_valid = 1'b0; s_last = 1'b0;
            chk("vec_en", wr_en, 64'hFF << 16);
            chk("vec_bank16", 64'(wr_data[16*32 +: 32]), 64'(ev[i].expv));
            chk("vec_bank23", 64'(wr_data[23*32 +: 32]), 64'(ev[i].expv));
        end

        // PACK A-operand load, one row per beat, no bubbles
        start(0, 0, 0, 8, 0, 8, 0);
        for (int i = 0; i < 8; i++) begin
            s_valid = 1'b1; s_data = {8{16'(i), 16'(i)}}; s_last = (i == 7);
            tick();
            chk("pack_row_en", wr_en, 64'hFF << (8 * i));
            chk("pack_word", 64'(wr_data[(8*i+3)*32 +: 32]), 64'({16'(i), 16'(i)}));
        end
        s_valid = 1'b0; s_last = 1'b0;
        chk("pack_err", 64'(err_last), 64'h0);
        tick();
        chk("pack_idle_busy", 64'(busy), 64'h0);

        // Partial words with wrap around the bank array
        start(0, 0, 0, 2, 62, 3, 0);
        for (int i = 0; i < 3; i++) begin
            s_valid = 1'b1; s_data = rnd256(); s_last = (i == 2);
            tick();
            chk("wrap_en", wr_en, wrap_exp[i]);
        end
        s_valid = 1'b0; s_last = 1'b0;
        tick();

        // Backpressure gaps
        start(0, 0, 0, 8, 8, 4, 0);
        sent = 0;
        for (int i = 0; i < 7; i++) begin
            s_valid = pat[i]; s_last = pat[i] && (sent == 3); s_data = rnd256();
            tick();
            if (pat[i]) begin
                chk("bp_en", wr_en, 64'hFF << (8 * (1 + sent)));
                sent++;
            end else chk("bp_idle", wr_en, 64'h0);
        end
        s_valid = 1'b0; s_last = 1'b0;
        tick();

        // Early last: beat 2 of 4, later beats not consumed
        start(0, 0, 0, 8, 0, 4, 0);
        drive(4, 0, 1);
        chk("early_err", 64'(err_last), 64'h1);
        s_valid = 1'b1;
        tick();
        chk("early_no_consume", wr_en, 64'h0);
        tick();
        s_valid = 1'b0;

        // Missing last on the final beat
        start(0, 0, 0, 8, 0, 4, 0);
        drive(4, 0, -1);
        chk("missing_last_err", 64'(err_last), 64'h1);
        chk("missing_last_ready", 64'(s_ready), 64'h0);

        // Zero-beat command completes at once
        start(0, 0, 0, 8, 0, 0, 0);
        chk("zero_beats_done", 64'(done), 64'h1);

        // Abort on beat 3 of 8, restart at base 40
        start(0, 0, 0, 8, 0, 8, 0);
        drive(2, 0, -1);
        start(0, 0, 0, 8, 40, 2, 1);
        chk("abort_drop", wr_en, 64'h0);
        s_valid = 1'b1; s_data = rnd256();
        tick();
        chk("abort_restart", wr_en, 64'hFF << 40);
        s_last = 1'b1;
        tick();
        s_valid = 1'b0; s_last = 1'b0;

        // Reset mid-transfer
        start(0, 0, 0, 8, 0, 8, 0);
        drive(2, 0, -1);
        rst_n = 1'b0; s_valid = 1'b1;
        tick();
        chk("rst_wr_en", wr_en, 64'h0);
        chk("rst_done", 64'(done), 64'h0);
        rst_n = 1'b1; s_valid = 1'b0;
        tick();

        // Randomized transfers against the model
        for (int t = 0; t < 60; t++) begin
            nb = $urandom_range(0, 6);
            mode = $urandom_range(0, 9);
            start($urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 1),
                  $urandom_range(0, 15), $urandom_range(0, 63), nb, $urandom_range(0, 1));
            if (mode == 0) drive(nb, 30, $urandom_range(0, 5));
            else if (mode == 1) drive(nb, 30, -1);
            else if (mode == 2) drive($urandom_range(0, 3), 30, -1);
            else drive(nb, 30, nb - 1);
            for (int i = 0; i < $urandom_range(0, 2); i++) tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/axi_tile_unpacker.md
# axi_tile_unpacker

Parametrised AXI read-data unpacker that takes a stream of wide read beats and scatters them into the ROWS×COLS SRAM bank array or systolic accumulator array. It supersedes the fixed 256-bit, externally-sequenced transformer. Beat sequencing is internal, and the AXI R channel is handled with valid/ready. Each transfer is configured by one start command. Two packing modes are supported: raw bank words (A/B operands) and per-element zero/sign extension (C accumulator preload). End-of-burst is checked, and completion is reported.

## Interface
Parameters:
- DATA_W, 256, AXI read data width; multiple of BANK_W.
- BANK_W, 32, bank word width.
- ROWS, 8, bank array rows.
- COLS, 8, bank array columns.
- BEAT_W, 8, width of the beat counter and of cfg_beats.
- WPB (derived), DATA_W/BANK_W, maximum words per beat.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- cfg_start  in  1  one-cycle pulse; latches all cfg_* fields and starts a transfer.
- cfg_beats  in  BEAT_W  number of beats expected.
- cfg_words  in  $clog2(WPB)+1  bank words written per beat.
- cfg_ext  in  1  mode select: 0 = PACK, 1 = EXTEND.
- cfg_ew  in  2  EXTEND element width: 0=4, 1=8, 2=16, 3=32 bits.
- cfg_sext  in  1  EXTEND only: 1 = sign-extend, 0 = zero-extend.
- cfg_base  in  $clog2(ROWS*COLS)  first linear bank index.
- s_valid  in  1  AXI R valid.
- s_ready  out  1  AXI R ready.
- s_data  in  DATA_W  AXI R data.
- s_last  in  1  AXI R last.
- wr_en  out  ROWS*COLS  per-bank write enable; bank (r,c) at bit r*COLS+c.
- wr_data  out  ROWS*COLS*BANK_W  per-bank write data, same indexing.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle completion pulse.
- err_last  out  1  sticky s_last mismatch flag.

## Operation
- States are IDLE and RUN.
- **IDLE → RUN** on cfg_start with cfg_beats≠0.
  - Latch the configuration.
  - Set ptr=cfg_base and beat_cnt=0.
  - Clear err_last.
- **cfg_start with cfg_beats=0**: stay in IDLE, pulse done the next cycle, clear err_last.
- **cfg_start while in RUN** aborts the current transfer and restarts with the new configuration. A beat handshaked in the same cycle is discarded (no wr_en).
- s_ready = (state==RUN). A beat is accepted when s_valid && s_ready.
- **Latched cfg_words of 0 or greater than WPB** is treated as WPB.
- **Accepted beat, k = 0..words-1:**
  - PACK: bank word k = s_data[k*BANK_W +: BANK_W].
  - EXTEND: bank word k = s_data[k*EW +: EW], extended to BANK_W bits (zero or sign per cfg_sext). EW=32 passes the element through unchanged.
  - Destination is linear index (ptr+k) mod ROWS*COLS, i.e. row = idx/COLS, col = idx%COLS.
  - Then ptr ← (ptr+words) mod ROWS*COLS and beat_cnt++.
- **Final beat** is the one where beat_cnt+1 == cfg_beats.
  - On acceptance: return to IDLE, pulse done.
  - err_last is set if s_last=0 on this beat.
- **Early s_last** (s_last=1 on a non-final beat): the beat is written, err_last is set, done pulses, and the block returns to IDLE. Remaining beats are never accepted.
- Banks not addressed in a cycle have wr_en=0; their wr_data is 0.
- wr_en is never asserted for a beat that was not accepted.

## Timing
- Reset (rst_n=0 at a clk edge):
  - state=IDLE, ptr=0, beat_cnt=0.
  - s_ready=0, busy=0, done=0, err_last=0, wr_en=0, wr_data=0.
  - Reset mid-transfer drops it with no done pulse.
- Beat accepted at edge t → wr_en/wr_data valid for exactly the cycle after edge t (1-cycle registered latency).
- done is asserted in the same cycle as the final beat's wr_en.
- busy=1 from the cycle after cfg_start until the cycle done is asserted, that cycle included. s_ready is combinational from state only.
- Full throughput: one beat per cycle with no bubbles; s_valid may stay high across consecutive beats.
- s_ready drops the cycle after the final or early-last beat. The s_valid/s_data of the next burst is not consumed until the next cfg_start.

## Test plan
- **PACK A-operand load.** Config: DATA_W=256, cfg_words=8, cfg_beats=8, cfg_base=0, s_data beat i = {8{i,i}} patterns, s_last on beat 7.
  - Row i banks get the beat-i words, one row per cycle; one wr_en row per cycle.
  - done and busy fall with beat 7; err_last=0.
- **EXTEND C preload with sign extension.** Config: cfg_ew=1, cfg_sext=1, cfg_words=8, cfg_beats=8, bytes 0x80 and 0x7F.
  - Banks receive 32'hFFFFFF80 and 32'h0000007F.
  - Repeat with cfg_sext=0: 32'h00000080.
- **Partial words and wrap.** Config: cfg_words=2, cfg_base=62, cfg_beats=3.
  - Beat 0 writes banks 62,63; beat 1 writes 0,1; beat 2 writes 2,3.
  - Exactly 2 wr_en bits per beat.
- **Backpressure/gaps.** Config: cfg_beats=4 with s_valid toggled 1,0,0,1,1,0,1.
  - wr_en appears only the cycle after each handshake; all 4 beats land in order.
- **Last mismatch.**
  - s_last on beat 2 of 4 → done after beat 2, err_last=1, s_ready=0, beat 3 not consumed.
  - Separately, beat 4 with s_last=0 → done, err_last=1.
- **Abort and reset.**
  - cfg_start during beat 3 of 8 → that beat is dropped, ptr restarts at the new cfg_base.
  - rst_n=0 mid-transfer → all outputs 0 next cycle, no done pulse.
